game_seq: RTL
=============

GAME_SEQ -- requirements
Module: game_seq

Interface
REQ-001 Parameter SERVE_FRAMES, default 60, number of frame ticks spent in SERVE before PLAY.
REQ-002 Parameter DEBOUNCE_FRAMES, default 3, consecutive frame-tick samples needed to accept a key level change.
REQ-003 Parameter LIVES, default 3, lives loaded at game start; 1..3 legal.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 vsync  input  1  vertical sync from the video timing datapath, clk domain.
REQ-007 keys  input  4  raw keys: [0] start, [1] pause, [2] left, [3] right.
REQ-008 ball_miss  input  1  one-cycle pulse: ball passed paddle.
REQ-009 brick_hit  input  1  one-cycle pulse: ball destroyed a brick.
REQ-010 state  output  3  IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4.
REQ-011 ball_en  output  1  ball motion enable.
REQ-012 ball_reset  output  1  hold ball at serve position.
REQ-013 paddle_en  output  1  paddle motion enable.
REQ-014 paddle_left, paddle_right  output  1 each  debounced keys[2], keys[3] gated by paddle_en.
REQ-015 score  output  8  two BCD digits, [7:4] tens, [3:0] units.
REQ-016 lives  output  2  remaining lives.
REQ-017 game_over  output  1  high in OVER.

Function
REQ-018 frame_tick SHALL be a one-cycle internal pulse on the cycle after vsync is sampled 1 having been sampled 0 the previous cycle.
REQ-019 Each key SHALL be sampled only on frame_tick; debounced level changes after DEBOUNCE_FRAMES consecutive equal samples differing from the current level.
REQ-020 start_press/pause_press SHALL be one-cycle pulses on the cycle the debounced start/pause level goes 0->1.
REQ-021 IDLE: start_press -> SERVE, load lives=LIVES, score=0.
REQ-022 SERVE: serve counter clears on entry, increments per frame_tick; at SERVE_FRAMES ticks -> PLAY.
REQ-023 PLAY: ball_miss with lives>1 -> lives-1, SERVE; ball_miss with lives==1 -> lives=0, OVER; pause_press -> PAUSE.
REQ-024 PAUSE: pause_press -> PLAY; ball_miss, brick_hit ignored.
REQ-025 OVER: start_press -> SERVE with lives=LIVES, score=0; score held until then.
REQ-026 brick_hit in PLAY SHALL increment score in BCD (09->10, 99 saturates at 99); ignored in other states.
REQ-027 ball_miss and brick_hit in the same PLAY cycle SHALL both take effect.
REQ-028 ball_miss and pause_press in the same PLAY cycle: miss wins, pause discarded.
REQ-029 All state/score/lives changes SHALL register on the clock edge following the triggering pulse (1-cycle latency).
REQ-030 ball_en = (state==PLAY); ball_reset = (state==SERVE); paddle_en = (state==SERVE or PLAY); game_over = (state==OVER); all decoded from registered state.

Reset
REQ-031 Asserting reset SHALL immediately force state=IDLE, score=0, lives=0, serve counter=0, all debounced levels and counters 0, vsync history 0.
REQ-032 Reset mid-game SHALL abandon the game with no residual press pulse after release.
REQ-033 Reset outputs: ball_en=0, ball_reset=0, paddle_en=0, paddle_left=0, paddle_right=0, game_over=0, state=0.

Structure
REQ-034 Package game_seq_pkg SHALL hold the state enum (3-bit) and default constants for SERVE_FRAMES, DEBOUNCE_FRAMES, LIVES.
REQ-035 Sub-module key_debounce (one key, frame_tick enable, level and rise-pulse outputs) SHALL be instantiated four times.

Verification
REQ-036 Reset, DEBOUNCE_FRAMES=3, hold keys[0]=1 for 3 frames -> one start_press, state 0->1, lives=3, score=0x00.
REQ-037 keys[0] high for only 2 frames -> no press, state stays IDLE.
REQ-038 In SERVE, count 60 frame ticks -> state=2 one cycle after the 60th tick, ball_en=1, ball_reset=0.
REQ-039 In PLAY, 12 brick_hit pulses -> score=0x12; 100 total pulses -> score=0x99.
REQ-040 Lives=1 in PLAY, ball_miss and brick_hit same cycle -> state=4, lives=0, score incremented, game_over=1.
REQ-041 In PLAY, ball_miss and pause_press same cycle -> state=1, lives decremented; reset mid-PAUSE -> state=0, all outputs at reset values.

Source files
------------

// File: rtl/game_seq_pkg.sv
// Shared types and defaults for the game sequencer: state encoding,
// parameter defaults and the saturating BCD score increment.
package game_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam int SERVE_FRAMES_DEF    = 60;
  localparam int DEBOUNCE_FRAMES_DEF = 3;
  localparam int LIVES_DEF           = 3;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)            r = v;
    else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
    else                       r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/game_seq_key.sv
// One-key debouncer: samples on the frame tick, accepts a new level after
// DEBOUNCE_FRAMES consecutive differing samples, and flags the 0->1 change.
module key_debounce
  import game_seq_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic key_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_FRAMES - 1);

  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    if (tick_i) begin
      if (key_i != level_q) begin
        if (cnt_q == LAST) begin
          level_d = key_i;
          cnt_d   = '0;
          rise_d  = key_i;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/game_seq.sv
// Game flow sequencer: frame tick from vsync, debounced keys, and the
// IDLE/SERVE/PLAY/PAUSE/OVER state machine with BCD score and lives.
module game_seq
  import game_seq_pkg::*;
#(
  parameter int SERVE_FRAMES    = SERVE_FRAMES_DEF,
  parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF,
  parameter int LIVES           = LIVES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic [3:0] keys,
  input  logic       ball_miss,
  input  logic       brick_hit,
  output logic [2:0] state,
  output logic       ball_en,
  output logic       ball_reset,
  output logic       paddle_en,
  output logic       paddle_left,
  output logic       paddle_right,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam int SW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_FRAMES - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

  state_e        state_q, state_d;
  logic [7:0]    score_q, score_d;
  logic [1:0]    lives_q, lives_d;
  logic [SW-1:0] serve_q, serve_d;
  logic [1:0]    vs_q;
  logic          frame_tick;
  logic [3:0]    key_lvl, key_rise;
  logic          start_press, pause_press;
  logic          unused_keys;

  assign frame_tick  = vs_q[0] & ~vs_q[1];
  assign start_press = key_rise[0];
  assign pause_press = key_rise[1];
  assign unused_keys = ^{key_lvl[1:0], key_rise[3:2]};

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_key (
      .clk    (clk),
      .rst_n  (reset),
      .tick_i (frame_tick),
      .key_i  (keys[i]),
      .level_o(key_lvl[i]),
      .rise_o (key_rise[i])
    );
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    serve_d = '0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_press) begin
          state_d = ST_SERVE;
          lives_d = LIVES_INIT;
          score_d = '0;
        end
      end
      ST_SERVE: begin
        serve_d = serve_q;
        if (frame_tick) begin
          if (serve_q == SERVE_LAST) state_d = ST_PLAY;
          else                       serve_d = serve_q + SW'(1);
        end
      end
      ST_PLAY: begin
        if (brick_hit) score_d = bcd_inc_sat(score_q);
        // A miss overrides a simultaneous pause request.
        if (ball_miss) begin
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            state_d = ST_SERVE;
          end else begin
            lives_d = 2'd0;
            state_d = ST_OVER;
          end
        end else if (pause_press) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_press) state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      lives_q <= '0;
      serve_q <= '0;
      vs_q    <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      serve_q <= serve_d;
      vs_q    <= {vs_q[0], vsync};
    end
  end

  assign state        = state_q;
  assign score        = score_q;
  assign lives        = lives_q;
  assign ball_en      = (state_q == ST_PLAY);
  assign ball_reset   = (state_q == ST_SERVE);
  assign paddle_en    = (state_q == ST_SERVE) || (state_q == ST_PLAY);
  assign game_over    = (state_q == ST_OVER);
  assign paddle_left  = key_lvl[2] & paddle_en;
  assign paddle_right = key_lvl[3] & paddle_en;

endmodule
